// File: rtl/dinorun_pkg.sv
// Shared display types and the hex-to-seven-segment glyph table.
package dinorun_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t      SEG7_BLANK_N = 7'h7F;
    localparam logic [3:0] AN_OFF_N     = 4'hF;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic seg7_t hex_to_seg7(input logic [3:0] hex);
        seg7_t seg;
        seg = '0;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment decoder.
module sevenseg_hex_decoder
    import dinorun_pkg::*;
(
    input  logic [3:0] hex,
    output seg7_t      seg
);

    assign seg = hex_to_seg7(hex);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking and a
// once-per-frame shadow capture so score updates never tear mid-frame.
module sevenseg_scan_driver
    import dinorun_pkg::*;
#(
    parameter int DWELL_CYCLES = 25175,
    parameter int BLANK_CYCLES = 1259
) (
    input  logic       clk_25_175_i,
    input  logic       rst_ni,
    input  logic       digit0_en_i,
    input  logic [3:0] digit0_i,
    input  logic       digit1_en_i,
    input  logic [3:0] digit1_i,
    input  logic       digit2_en_i,
    input  logic [3:0] digit2_i,
    input  logic       digit3_en_i,
    input  logic [3:0] digit3_i,
    output logic [3:0] an_no,
    output logic [6:0] seg_no,
    output logic       frame_o
);

    localparam int             CW        = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [3:0]      sh_en;
    logic [3:0][3:0] sh_val;

    logic       slot_end;
    logic       frame_load;
    logic       drive;
    seg7_t      seg_hi;
    logic [3:0] an_next;
    logic [6:0] seg_next;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_load = slot_end && (idx == 2'd3);

    sevenseg_hex_decoder u_dec (
        .hex (sh_val[idx]),
        .seg (seg_hi)
    );

    // Anode and segments are chosen together from the same state so they
    // always switch in the same cycle.
    always_comb begin
        drive    = (cnt >= CNT_BLANK) && sh_en[idx];
        an_next  = AN_OFF_N;
        seg_next = SEG7_BLANK_N;
        if (drive) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = ~seg_hi;
        end
    end

    always_ff @(posedge clk_25_175_i) begin
        if (!rst_ni) begin
            cnt     <= '0;
            idx     <= '0;
            sh_en   <= '0;
            sh_val  <= '0;
            an_no   <= AN_OFF_N;
            seg_no  <= SEG7_BLANK_N;
            frame_o <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end)
                idx <= idx + 2'd1;
            if (frame_load) begin
                sh_en  <= {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i};
                sh_val <= {digit3_i, digit2_i, digit1_i, digit0_i};
            end
            frame_o <= frame_load;
            an_no   <= an_next;
            seg_no  <= seg_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with DWELL=8, BLANK=2 (32-cycle frame).
module tb_sevenseg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       digit0_en_i, digit1_en_i, digit2_en_i, digit3_en_i;
    logic [3:0] digit0_i, digit1_i, digit2_i, digit3_i;
    logic [3:0] an_no;
    logic [6:0] seg_no;
    logic       frame_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected active-low segment bus per hex value, worked out by hand.
    localparam logic [6:0] SEGN [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sevenseg_scan_driver #(.DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk_25_175_i (clk),
        .rst_ni       (rst_ni),
        .digit0_en_i  (digit0_en_i),
        .digit0_i     (digit0_i),
        .digit1_en_i  (digit1_en_i),
        .digit1_i     (digit1_i),
        .digit2_en_i  (digit2_en_i),
        .digit2_i     (digit2_i),
        .digit3_en_i  (digit3_en_i),
        .digit3_i     (digit3_i),
        .an_no        (an_no),
        .seg_no       (seg_no),
        .frame_o      (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_in(input logic [3:0] en, input logic [3:0][3:0] val);
        {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i} = en;
        {digit3_i, digit2_i, digit1_i, digit0_i}             = val;
    endtask

    // Advance one cycle and check frame offset i (1..32) after a load cycle.
    task automatic check_cyc(input string tag, input int i, input logic [3:0] en,
                             input logic [3:0][6:0] segs);
        int         s, o;
        logic [3:0] ea;
        logic [6:0] es;
        step();
        s  = (i - 1) / 8;
        o  = (i - 1) % 8;
        ea = 4'hF;
        es = 7'h7F;
        if (o >= 2 && en[s]) begin
            ea = ~(4'b0001 << s);
            es = segs[s];
        end
        chk({tag, "_an"}, an_no, ea);
        chk({tag, "_seg"}, seg_no, es);
        chk({tag, "_frame"}, frame_o, (i == 32));
    endtask

    task automatic check_frame(input string tag, input logic [3:0] en,
                               input logic [3:0][6:0] segs);
        for (int i = 1; i <= 32; i++) check_cyc(tag, i, en, segs);
    endtask

    // Cycle-by-cycle invariants against an independently tracked shadow copy.
    logic            mon_on = 1'b0;
    logic            rst_pend = 1'b0;
    logic [3:0]      in_en, sh_en, shp_en;
    logic [3:0][3:0] in_val, sh_val, shp_val;
    int              since = 0;

    always @(negedge clk) begin
        if (rst_pend) begin
            if (mon_on) begin
                chk("mon_rst_an", an_no, 4'hF);
                chk("mon_rst_seg", seg_no, 7'h7F);
            end
            sh_en = '0; sh_val = '0; shp_en = '0; shp_val = '0;
            since = 0;
        end else if (mon_on) begin
            shp_en  = sh_en;
            shp_val = sh_val;
            since++;
            if (frame_o) begin
                chk("mon_frame_period", since, 32);
                since  = 0;
                sh_en  = in_en;
                sh_val = in_val;
            end else if (since == 33) begin
                chk("mon_frame_late", since, 32);
            end
            chk("mon_onehot", ($countones(~an_no) <= 1), 1);
            if (an_no != 4'hF) begin
                for (int b = 0; b < 4; b++) begin
                    if (!an_no[b]) begin
                        chk("mon_en", shp_en[b], 1);
                        chk("mon_seg", seg_no, SEGN[shp_val[b]]);
                    end
                end
            end else begin
                chk("mon_dark_seg", seg_no, 7'h7F);
            end
        end
        in_en    = {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i};
        in_val   = {digit3_i, digit2_i, digit1_i, digit0_i};
        rst_pend = !rst_ni;
    end

    initial begin
        rst_ni = 1'b0;
        set_in(4'hF, {4'h4, 4'h3, 4'h2, 4'h1});
        step();
        step();
        rst_ni = 1'b1;
        cyc    = 0;
        mon_on = 1'b1;
        chk("rst_an", an_no, 4'hF);
        chk("rst_seg", seg_no, 7'h7F);
        chk("rst_frame", frame_o, 0);

        // First frame after reset is dark; load at cycle 32.
        check_frame("t1_dark", 4'h0, '0);
        check_frame("t1_1234", 4'hF, {7'h19, 7'h30, 7'h24, 7'h79});

        // Sweep digit0 through every glyph, one value per frame.
        set_in(4'h1, {4'h0, 4'h0, 4'h0, 4'h0});
        check_frame("t2_pre", 4'hF, {7'h19, 7'h30, 7'h24, 7'h79});
        for (int v = 0; v < 16; v++) begin
            if (v < 15) set_in(4'h1, {4'h0, 4'h0, 4'h0, 4'(v + 1)});
            else        set_in(4'hB, {4'hA, 4'h9, 4'h8, 4'h7});
            check_frame("t2_sweep", 4'h1, {7'h7F, 7'h7F, 7'h7F, SEGN[v]});
        end

        // Digit 2 disabled: its slot stays dark.
        set_in(4'hF, {4'hF, 4'hE, 4'h5, 4'hC});
        check_frame("t3_dis2", 4'hB, {7'h08, 7'h10, 7'h00, 7'h78});

        // Mid-frame change of digit1 is invisible until the next load.
        for (int i = 1; i <= 32; i++) begin
            check_cyc("t4_old", i, 4'hF, {7'h0E, 7'h06, 7'h12, 7'h46});
            if (i == 8) digit1_i = 4'h9;
        end
        for (int i = 1; i <= 20; i++)
            check_cyc("t4_new", i, 4'hF, {7'h0E, 7'h06, 7'h10, 7'h46});

        // Reset pulse during DRIVE of slot 2.
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        cyc    = 0;
        chk("t5_rst_an", an_no, 4'hF);
        chk("t5_rst_seg", seg_no, 7'h7F);
        chk("t5_rst_frame", frame_o, 0);
        check_frame("t5_dark", 4'h0, '0);
        check_frame("t5_after", 4'hF, {7'h0E, 7'h06, 7'h10, 7'h46});

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Consumer end of the game core's four-digit score interface (per digit: enable + 4-bit hex value). It time-multiplexes the four digits onto a common-cathode-bus, anode-select seven-segment display with active-low drive. An anti-ghosting blank interval opens each digit slot. Inputs are latched into a shadow register once per scan frame, so a score update never tears mid-frame.

Parameters:
DWELL_CYCLES, 25175, clocks per digit slot (~1 ms at 25.175 MHz); must be >= 2
BLANK_CYCLES, 1259, clocks at the start of each slot with all anodes off; 0 <= BLANK_CYCLES < DWELL_CYCLES

Ports:
clk_25_175_i  input  1  system clock, the only clock
rst_ni  input  1  synchronous active-low reset
digit0_en_i  input  1  digit 0 (rightmost, anode 0) lit when 1
digit0_i  input  4  digit 0 hex value
digit1_en_i  input  1  digit 1 enable
digit1_i  input  4  digit 1 value
digit2_en_i  input  1  digit 2 enable
digit2_i  input  4  digit 2 value
digit3_en_i  input  1  digit 3 (leftmost) enable
digit3_i  input  4  digit 3 value
an_no  output  4  anode selects, active-low, bit n = digit n
seg_no  output  7  segments {g,f,e,d,c,b,a}, active-low
frame_o  output  1  one-cycle pulse on the cycle the shadow register loads

Behaviour:
- One clock domain, clk_25_175_i. Reset is synchronous and active-low on rst_ni. All state updates on the rising edge.
- State:
  - slot counter cnt, width $clog2(DWELL_CYCLES), counts 0..DWELL_CYCLES-1 and wraps to 0.
  - digit index idx, 2 bits, increments when cnt wraps; wraps 3->0.
  - shadow register: 4 enables + 4 values.
- Reset values:
  - cnt=0, idx=0.
  - shadow enables all 0, values 0.
  - an_no=4'hF, seg_no=7'h7F, frame_o=0.
  - The first frame after reset is therefore fully dark.
- Slot phases, derived from cnt (no separate FSM register needed):
  - BLANK: cnt < BLANK_CYCLES.
  - DRIVE: otherwise.
- Frame load: when cnt==DWELL_CYCLES-1 and idx==3, the shadow captures all eight inputs on that edge, and frame_o registers 1 for the following cycle.
  - Inputs are sampled at no other time.
  - Input changes during a frame are invisible until the next load.
- Output registers, computed from the current-cycle state, so outputs lag state by exactly one clock:
  - BLANK phase, or shadow enable[idx]==0: an_no=4'hF, seg_no=7'h7F.
  - DRIVE phase with enable[idx]==1: an_no=~(4'b0001<<idx), seg_no=~hex7(shadow value[idx]).
- Anodes and segments always switch in the same cycle. An anode is never asserted with the previous slot's segments.
- hex7 table, active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Frame period is 4*DWELL_CYCLES.
- Each enabled digit is driven DWELL_CYCLES-BLANK_CYCLES cycles per frame. With BLANK_CYCLES=0 there is no dark interval.
- Reset asserted mid-frame: on the next edge all state returns to reset values, outputs go dark, and the scan restarts at idx 0, cnt 0. No partial frame load occurs.
- No handshake. Inputs are level signals from the same clock domain; no synchronizer is required.

Decomposition:
- dinorun_pkg gains:
  - typedef seg7_t (logic [6:0]).
  - constants SEG7_BLANK_N=7'h7F and AN_OFF_N=4'hF.
  - pure function hex_to_seg7 (4-bit in, active-high seg7_t out) holding the table above.
- One natural sub-module: sevenseg_hex_decoder. It is combinational, wraps hex_to_seg7, and is instantiated once on the muxed shadow value.
- Counter, index, shadow and output registers live in sevenseg_scan_driver.

Test Plan:
All scenarios use DWELL_CYCLES=8, BLANK_CYCLES=2, frame = 32 cycles.
1. Reset, then hold digits 1,2,3,4 (digit3..0 = 4,3,2,1), all enabled:
   - first 32+1 cycles: an_no=F, seg_no=7F.
   - frame_o pulses once at cycle 32.
   - then per slot: 2 cycles dark, then 6 cycles an_no=E, seg_no=79 ("1").
   - next slots: an_no=D seg_no=24, an_no=B seg_no=30, an_no=7 seg_no=19.
2. Sweep values 0..F on digit0 only, one per frame:
   - seg_no equals ~table for every value.
   - an_no never shows any bit other than 0 low.
3. digit2_en_i=0, others enabled:
   - slot 2 stays an_no=F, seg_no=7F for all 8 cycles.
   - the other slots are unaffected.
4. Change digit1_i from 5 to 9 at cycle 40, mid-frame:
   - slot 1 of the current frame still shows 5 (seg_no=12).
   - the next frame shows 9 (seg_no=10).
5. Assert rst_ni=0 for 1 cycle during the DRIVE phase of slot 2:
   - the next cycle after reset, an_no=F.
   - scan restarts at slot 0 and the next frame_o arrives 32 cycles later.
   - display is dark until that load.
6. Every cycle, assertion:
   - an_no has at most one bit low.
   - whenever an_no!=F, seg_no matches the shadow value for the low bit.
   - frame_o period is exactly 32 cycles.
